fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage of the RV32I core. It owns the PC and issues word requests to instruction memory over a req/ack handshake. It registers each returned instruction, together with its PC and PC+4, into the IF/ID slot. The decode stage, which drives the immediate generator, consumes from that slot. The stage handles decode stalls with a one-entry skid buffer and handles branch/jump redirects, including redirects that arrive while a memory request is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction word presented on id_inst when the slot is empty or after reset (ADDI x0,x0,0).

Ports:
CLK  input  1  system clock, rising edge
RST_n  input  1  asynchronous active-low reset
imem_req  output  1  instruction memory request
imem_addr  output  32  word address (byte address, bits [1:0]=0)
imem_ack  input  1  imem_rdata valid this cycle; only meaningful while imem_req=1
imem_rdata  input  32  instruction word
redirect_valid  input  1  branch/jump taken, one-cycle pulse
redirect_pc  input  32  redirect target
id_stall  input  1  decode cannot accept this cycle
id_valid  output  1  IF/ID slot holds a valid instruction
id_inst  output  32  instruction to decode
id_pc  output  32  PC of id_inst
id_pc4  output  32  id_pc+4 (registered)

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (RST_n).
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_inst=NOP_INST, id_pc=0, id_pc4=0, skid empty.
- Slot free is defined as (!id_valid || !id_stall).
- State IDLE: the first edge after reset release moves to REQ.
- State REQ: imem_req=1 and imem_addr=pc. Address is stable until imem_ack.
  - On imem_ack with slot free: id_inst<=imem_rdata, id_pc<=pc, id_pc4<=pc+4, id_valid<=1, pc<=pc+4. Stay in REQ. Back-to-back issue gives one instruction per cycle on single-cycle ack.
  - On imem_ack with slot blocked: data and PC go to the skid buffer, pc<=pc+4, go to HOLD.
  - If no ack arrives: stay in REQ. If the slot is consumed (!id_stall), id_valid<=0.
- State HOLD: imem_req=0. When !id_stall, the skid buffer moves into the slot (id_valid=1) and the state returns to REQ.
- State KILL: imem_req=1 with the old address held. The next imem_ack data is discarded, then the state goes to REQ with the updated pc.
- Redirect has the highest priority in every state. It sets pc<=redirect_pc, id_valid<=0, id_inst<=NOP_INST, and empties the skid buffer.
  - From REQ without ack in the same cycle: go to KILL.
  - From REQ with ack in the same cycle: ack data is dropped; go to REQ at redirect_pc.
  - From HOLD: go to REQ.
  - From KILL: stay in KILL with the new target.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Latency: the slot is valid one edge after the ack edge.
- Reset mid-request: the state machine aborts immediately and imem_req drops asynchronously.
- The memory must not ack while imem_req=0. Such an ack is ignored.

Optional Feature:
FETCH_MISALIGN_CHK_EN
- Enabled:
  - Adds output port fetch_misalign (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 (sticky until reset) and moves the state to IDLE. In IDLE the stage issues no further requests.
- Disabled:
  - No port is added.
  - redirect_pc[1:0] are forced to 0 when loaded.

Test Plan:
- Reset release, single-cycle ack, rdata=32'h00500093 at address 0 and 32'h00A00113 at address 4 -> imem_addr sequence 0,4,8. Slot shows id_pc=0 with inst 32'h00500093, then id_pc=4 with inst 32'h00A00113. id_pc4=4 then 8.
- id_stall=1 held for 3 cycles while an ack arrives for address 8 -> HOLD is entered and imem_req=0. Slot keeps PC 4 and the skid holds PC 8. After the stall releases, id_pc=8, then fetch resumes at address 12.
- Ack delayed 3 cycles -> imem_addr stable for all 3 cycles and id_valid=0 once the slot is consumed.
- Redirect to 32'h00000100 while the request for 12 is outstanding -> KILL state. The ack for 12 is discarded and never appears on id_*. The next imem_addr is 32'h100 and the first valid id_pc is 32'h100.
- Redirect in the same cycle as an ack -> the acked instruction is dropped and id_valid=0 in the next cycle. Separately, with pc=32'hFFFFFFFC and an ack, the next imem_addr is 0.
- With FETCH_MISALIGN_CHK_EN defined, redirect_pc=32'h102 -> fetch_misalign=1 and imem_req stays 0 until RST_n is asserted.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch stage.
// Owns the PC, requests instruction words over a req/ack handshake, and fills
// the IF/ID slot. A one-entry skid buffer absorbs a returned word while decode
// is stalled. Redirects flush the slot and the skid; a redirect that catches a
// request in flight parks in KILL until that stale word comes back.
// Optional build macro FETCH_MISALIGN_CHK_EN: flags misaligned redirect targets
// on fetch_misalign and halts fetching until reset.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] addr_reg, addr_next;
    logic        id_valid_reg, id_valid_next;
    logic [31:0] id_inst_reg, id_inst_next;
    logic [31:0] id_pc_reg, id_pc_next;
    logic [31:0] id_pc4_reg, id_pc4_next;
    logic        skid_valid_reg, skid_valid_next;
    logic [31:0] skid_inst_reg, skid_inst_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic        misalign_reg, misalign_next;

    logic        ack;
    logic        slot_free;
    logic [31:0] redirect_target;

    // Request is a pure function of state so an async reset drops it at once.
    assign imem_req  = (state_reg == REQ) || (state_reg == KILL);
    assign imem_addr = addr_reg;
    assign id_valid  = id_valid_reg;
    assign id_inst   = id_inst_reg;
    assign id_pc     = id_pc_reg;
    assign id_pc4    = id_pc4_reg;
`ifdef FETCH_MISALIGN_CHK_EN
    assign fetch_misalign = misalign_reg;
    assign redirect_target = redirect_pc;
`else
    assign redirect_target = {redirect_pc[31:2], 2'b00};
`endif

    // An ack while no request is outstanding is ignored.
    assign ack       = imem_ack && imem_req;
    assign slot_free = !id_valid_reg || !id_stall;

    // Next-state, PC, slot and skid logic; redirect overrides everything.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        id_valid_next   = id_valid_reg;
        id_inst_next    = id_inst_reg;
        id_pc_next      = id_pc_reg;
        id_pc4_next     = id_pc4_reg;
        skid_valid_next = skid_valid_reg;
        skid_inst_next  = skid_inst_reg;
        skid_pc_next    = skid_pc_reg;
        misalign_next   = misalign_reg;

        // Decode takes the slot whenever it is not stalling.
        if (!id_stall) begin
            id_valid_next = 1'b0;
            id_inst_next  = NOP_INST;
        end

        case (state_reg)
            IDLE: begin
                if (!misalign_reg)
                    state_next = REQ;
            end
            REQ: begin
                if (ack) begin
                    pc_next = pc_reg + 32'd4;
                    if (slot_free) begin
                        id_valid_next = 1'b1;
                        id_inst_next  = imem_rdata;
                        id_pc_next    = pc_reg;
                        id_pc4_next   = pc_reg + 32'd4;
                    end else begin
                        skid_valid_next = 1'b1;
                        skid_inst_next  = imem_rdata;
                        skid_pc_next    = pc_reg;
                        state_next      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!id_stall) begin
                    id_valid_next   = 1'b1;
                    id_inst_next    = skid_inst_reg;
                    id_pc_next      = skid_pc_reg;
                    id_pc4_next     = skid_pc_reg + 32'd4;
                    skid_valid_next = 1'b0;
                    state_next      = REQ;
                end
            end
            KILL: begin
                // The stale word is dropped; resume at the redirected PC.
                if (ack)
                    state_next = REQ;
            end
            default: state_next = IDLE;
        endcase

        if (redirect_valid) begin
            pc_next         = redirect_target;
            id_valid_next   = 1'b0;
            id_inst_next    = NOP_INST;
            skid_valid_next = 1'b0;
            // A request still in flight must be drained before refetching.
            if (((state_reg == REQ) || (state_reg == KILL)) && !ack)
                state_next = KILL;
            else
                state_next = REQ;
`ifdef FETCH_MISALIGN_CHK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_next = 1'b1;
                state_next    = IDLE;
            end
`endif
        end

        if (misalign_reg)
            state_next = IDLE;
    end

    // Address follows the PC except while a killed request is still outstanding.
    always_comb begin
        addr_next = pc_next;
        if (state_next == KILL)
            addr_next = addr_reg;
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            addr_reg       <= RESET_PC;
            id_valid_reg   <= 1'b0;
            id_inst_reg    <= NOP_INST;
            id_pc_reg      <= 32'd0;
            id_pc4_reg     <= 32'd0;
            skid_valid_reg <= 1'b0;
            skid_inst_reg  <= NOP_INST;
            skid_pc_reg    <= 32'd0;
            misalign_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            addr_reg       <= addr_next;
            id_valid_reg   <= id_valid_next;
            id_inst_reg    <= id_inst_next;
            id_pc_reg      <= id_pc_next;
            id_pc4_reg     <= id_pc4_next;
            skid_valid_reg <= skid_valid_next;
            skid_inst_reg  <= skid_inst_next;
            skid_pc_reg    <= skid_pc_next;
            misalign_reg   <= misalign_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. Memory returns a fixed word
// per address; ack timing, stalls and redirects are stepped by hand.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0004: mem_word = 32'h00A0_0113;
            default:       mem_word = 32'h1000_0000 ^ a;
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage dut (
        .CLK            (CLK),
        .RST_n          (RST_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_n = 1'b0; imem_ack = 1'b0; id_stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        tick(); tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_inst", id_inst, NOP);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_pc4", id_pc4, 32'd0);
        $display("reset checked");

        RST_n = 1'b1;
        tick();
        chk("idle_to_req", {31'd0, imem_req}, 32'd1);
        chk("addr0", imem_addr, 32'd0);
        imem_ack = 1'b1;
        tick();
        chk("f0_valid", {31'd0, id_valid}, 32'd1);
        chk("f0_pc", id_pc, 32'd0);
        chk("f0_inst", id_inst, 32'h0050_0093);
        chk("f0_pc4", id_pc4, 32'd4);
        chk("addr4", imem_addr, 32'd4);
        tick();
        chk("f1_pc", id_pc, 32'd4);
        chk("f1_inst", id_inst, 32'h00A0_0113);
        chk("f1_pc4", id_pc4, 32'd8);
        chk("addr8", imem_addr, 32'd8);
        $display("back-to-back fetch of 0,4 checked");

        // Stall while ack for 8 arrives; ack left high during HOLD must be ignored.
        id_stall = 1'b1;
        tick();
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_pc_a", id_pc, 32'd4);
        chk("hold_valid", {31'd0, id_valid}, 32'd1);
        tick();
        chk("hold_pc_b", id_pc, 32'd4);
        tick();
        chk("hold_pc_c", id_pc, 32'd4);
        chk("hold_req_c", {31'd0, imem_req}, 32'd0);
        id_stall = 1'b0; imem_ack = 1'b0;
        tick();
        chk("skid_pc", id_pc, 32'd8);
        chk("skid_pc4", id_pc4, 32'd12);
        chk("skid_inst", id_inst, 32'h1000_0008);
        chk("skid_valid", {31'd0, id_valid}, 32'd1);
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'd12);
        $display("stall and skid checked");

        // No ack for three cycles.
        tick();
        chk("wait_valid", {31'd0, id_valid}, 32'd0);
        chk("wait_inst", id_inst, NOP);
        chk("wait_addr1", imem_addr, 32'd12);
        tick();
        chk("wait_addr2", imem_addr, 32'd12);
        tick();
        chk("wait_addr3", imem_addr, 32'd12);
        $display("delayed ack checked");

        // Redirect while request for 12 is outstanding.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("kill_req", {31'd0, imem_req}, 32'd1);
        chk("kill_addr", imem_addr, 32'd12);
        chk("kill_valid", {31'd0, id_valid}, 32'd0);
        imem_ack = 1'b1;
        tick();
        chk("kill_drop", {31'd0, id_valid}, 32'd0);
        chk("kill_newaddr", imem_addr, 32'h0000_0100);
        tick();
        chk("tgt_valid", {31'd0, id_valid}, 32'd1);
        chk("tgt_pc", id_pc, 32'h0000_0100);
        chk("tgt_inst", id_inst, 32'h1000_0100);
        chk("tgt_next", imem_addr, 32'h0000_0104);
        $display("redirect during outstanding request checked");

        // Redirect coinciding with an ack.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        chk("rdack_valid", {31'd0, id_valid}, 32'd0);
        chk("rdack_inst", id_inst, NOP);
        chk("rdack_addr", imem_addr, 32'h0000_0200);
        $display("redirect with ack checked");

        // PC wrap at the top of the address space.
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_addr_a", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc4, 32'd0);
        chk("wrap_addr", imem_addr, 32'd0);
        $display("pc wrap checked");

        // Misaligned redirect target.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_flag", {31'd0, fetch_misalign}, 32'd1);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        tick(); tick();
        chk("mis_req_held", {31'd0, imem_req}, 32'd0);
        chk("mis_flag_held", {31'd0, fetch_misalign}, 32'd1);
`else
        chk("mis_addr", imem_addr, 32'h0000_0100);
        chk("mis_req", {31'd0, imem_req}, 32'd1);
`endif
        $display("misaligned redirect checked");

        // Asynchronous reset in the middle of a cycle.
        imem_ack = 1'b0;
        #3;
        RST_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_valid", {31'd0, id_valid}, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("arst_mis", {31'd0, fetch_misalign}, 32'd0);
`endif
        $display("async reset checked");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
